sv_pin_responder: RTL

Pin-level command responder that sits directly behind the `tt_um_sv` top-level pins and serves the cocotb host.
- The host initiates byte transfers with a four-phase req/ack handshake on `uio[1:0]` and carries bytes on `ui_in`.
- The block decodes each command, reads or updates a small register file, and returns a response byte on `uo_out`.
- It is the target-side end of the host-driven pin protocol and is instantiated inside `tt_um_sv`.

---
 rtl/sv_pkg.sv | 17 +
 rtl/sv_pin_responder_if.sv | 29 ++
 rtl/sv_sync2.sv | 24 ++
 rtl/sv_pin_responder.sv | 99 +++++++++
 4 files changed

// File: rtl/sv_pkg.sv
// Shared constants and types for the tt_um_sv pin-level responder.
package sv_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_INC   = 2'b11;

    localparam logic [7:0] ID_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StAck
    } state_e;

endpackage

// File: rtl/sv_pin_responder_if.sv
// Top-level pin bundle between the cocotb host and the responder.
interface sv_pin_responder_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/sv_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; resets to 0.
module sv_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sv_pin_responder.sv
// Command responder: four-phase req/ack on uio, command/data on ui_in, response on uo_out.
module sv_pin_responder
    import sv_pkg::*;
#(
    parameter logic [7:0]  ID_BYTE = ID_BYTE_DEFAULT,
    parameter int unsigned NREGS   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sv_pin_responder_if.slave  pins
);

    state_e     state_q;
    logic [7:0] cmd_q;
    logic [7:0] resp_q;
    logic       ack_q;
    logic       wr_pend_q;
    logic [1:0] wr_addr_q;
    logic [7:0] regs_q [NREGS];

    logic       req_s;
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] inc_val;
    logic       unused_uio;

    // ui_in is held stable by the protocol, so only req needs synchronizing.
    sv_sync2 u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pins.uio_in[0]),
        .q     (req_s)
    );

    assign op         = cmd_q[7:6];
    assign addr       = cmd_q[1:0];
    assign inc_val    = regs_q[addr] + 8'd1;
    assign unused_uio = ^pins.uio_in[7:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cmd_q     <= 8'h00;
            resp_q    <= 8'h00;
            ack_q     <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= 2'b00;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_s && pins.ena) begin
                        cmd_q   <= pins.ui_in;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    ack_q   <= 1'b1;
                    state_q <= StAck;
                    // A pending write swallows this byte as data regardless of its opcode.
                    if (wr_pend_q) begin
                        regs_q[wr_addr_q] <= cmd_q;
                        resp_q            <= cmd_q;
                        wr_pend_q         <= 1'b0;
                    end else begin
                        unique case (op)
                            OP_NOP:   resp_q <= ID_BYTE;
                            OP_WRITE: begin
                                resp_q    <= cmd_q;
                                wr_pend_q <= 1'b1;
                                wr_addr_q <= addr;
                            end
                            OP_READ:  resp_q <= regs_q[addr];
                            OP_INC:   begin
                                regs_q[addr] <= inc_val;
                                resp_q       <= inc_val;
                            end
                            default:  resp_q <= ID_BYTE;
                        endcase
                    end
                end
                StAck: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pins.uo_out  = resp_q;
    assign pins.uio_out = {6'b000000, ack_q, 1'b0};
    assign pins.uio_oe  = 8'h02;

endmodule
